chained_match_pipe: RTL
=======================

# chained_match_pipe

Parametrised, pipelined successor to the single-cycle chained two-input comparator. It evaluates a multi-field key against a small rule table, one field per pipeline stage, and AND-chains the per-rule results across the stages. Each field is compared with a per-rule operator: don't-care, equal, less-than or greater-than. The block reports the lowest-index matching rule and keeps saturating lookup and hit counters. It sits in the SDN match path, between header-field extraction and the action stage.

## Interface
- FIELD_W, 2, width of one key field in bits (≥1)
- NUM_FIELDS, 2, fields per key; also the number of pipeline stages (≥1)
- NUM_RULES, 4, rule table entries (≥1, power of two)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  key present
- in_ready  out  1  key accepted when in_valid & in_ready
- in_key  in  FIELD_W*NUM_FIELDS  field i = in_key[i*FIELD_W +: FIELD_W]
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid & out_ready
- out_hit  out  1  at least one enabled rule matched
- out_idx  out  log2(NUM_RULES)  lowest matching rule index; 0 when out_hit=0
- cfg_we  in  1  rule-table write request
- cfg_ready  out  1  write accepted when cfg_we & cfg_ready
- cfg_rule  in  log2(NUM_RULES)  rule to write
- cfg_field  in  log2(NUM_FIELDS) (min 1)  field to write
- cfg_op  in  2  00 don't-care, 01 EQ, 10 LT, 11 GT
- cfg_value  in  FIELD_W  comparison value
- cfg_en  in  1  rule enable bit, written together with the field
- lookup_cnt  out  16  accepted keys, saturating
- hit_cnt  out  16  results with out_hit=1, saturating

## Operation
- Rule table holds, per rule: an enable bit, plus an op and a value for each field. Reset: all enables 0, all ops 00, all values 0.
- Field compare uses unsigned arithmetic:
  - 00: true
  - 01: key == value
  - 10: key < value
  - 11: key > value
- Stage s holds a valid bit, the remaining key, and a NUM_RULES-bit match vector.
  - Stage 0 match vector = enable & compare(field 0).
  - Stage s match vector = previous stage's vector & compare(field s).
  - The last stage priority-encodes its vector into out_hit and out_idx (lowest index wins) and registers the result.
- Global advance: adv = ~out_valid | out_ready. When adv=0, every stage holds its contents, including bubbles.
- cfg_ready = 1 only when every stage valid and out_valid are 0 (pipeline empty).
- in_ready = adv & ~(cfg_we & cfg_ready). A config write takes priority over a key in the same cycle.
- A write updates op, value and enable for (cfg_rule, cfg_field) at the accepting edge. Keys accepted later see the new contents.
- lookup_cnt increments on each key accept.
- hit_cnt increments on each result handshake with out_hit=1.
- Both counters stop at 16'hFFFF.
- A rule with all ops 00 and enable 1 matches every key. A rule with enable 0 never matches.

## Timing
- Reset values: in_ready=1, cfg_ready=1, out_valid=0, out_hit=0, out_idx=0, lookup_cnt=0, hit_cnt=0. All stage valids are 0.
- Latency: a key accepted at edge T produces out_valid=1 after edge T+NUM_FIELDS-1 (NUM_FIELDS cycles from accept to result), with no stalls.
- Throughput is one key per cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, out_hit and out_idx stay stable and in_ready=0.
- Accept and drain in the same cycle (out_ready=1 with in_valid=1) are both legal; there is no bubble.
- cfg_we while the pipeline is non-empty: cfg_ready=0, the write is held off and in_ready follows adv. The requester keeps cfg_* stable until accepted.
- Reset asserted mid-operation: all in-flight keys are discarded, outputs return to reset values immediately, and the rule table is cleared.

## Test plan
- Reset, then key 4'b0000 with an empty table -> after 2 cycles, out_valid=1, out_hit=0, out_idx=0; lookup_cnt=1, hit_cnt=0.
- Program rule 2 (field0 EQ 01, field1 GT 00, en=1). Key field0=01, field1=11 -> out_hit=1, out_idx=2. Key field0=01, field1=00 -> out_hit=0.
- Program rule 1 (all don't-care, en=1) and rule 3 (field0 LT 10, en=1). Key field0=01 -> out_idx=1 (lowest index wins).
- Stream 4 keys back-to-back with out_ready=1 -> 4 results in consecutive cycles, in order. Then hold out_ready=0 for 3 cycles -> outputs stable and in_ready=0. Release -> the remaining results follow with none lost.
- Assert cfg_we while 2 keys are in flight -> cfg_ready=0 until the pipe drains; the write is accepted on the first empty cycle, and a simultaneous in_valid is held off that cycle.
- Preload lookup_cnt to 16'hFFFE by streaming keys (or a reduced-width build), then 3 more hits -> both counters saturate at 16'hFFFF. Assert rst_n=0 mid-stream -> out_valid=0, counters 0, and the table is cleared.

Source files
------------

// File: rtl/chained_match_pipe_if.sv
// rtl/chained_match_pipe_if.sv - key, result, rule-config and counter bundle for chained_match_pipe
interface chained_match_pipe_if #(
    parameter int FIELD_W    = 2,
    parameter int NUM_FIELDS = 2,
    parameter int NUM_RULES  = 4
) ();
    localparam int KEY_W  = FIELD_W * NUM_FIELDS;
    localparam int IDX_W  = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;
    localparam int FSEL_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    logic               in_valid;
    logic               in_ready;
    logic [KEY_W-1:0]   in_key;
    logic               out_valid;
    logic               out_ready;
    logic               out_hit;
    logic [IDX_W-1:0]   out_idx;
    logic               cfg_we;
    logic               cfg_ready;
    logic [IDX_W-1:0]   cfg_rule;
    logic [FSEL_W-1:0]  cfg_field;
    logic [1:0]         cfg_op;
    logic [FIELD_W-1:0] cfg_value;
    logic               cfg_en;
    logic [15:0]        lookup_cnt;
    logic [15:0]        hit_cnt;

    modport master (
        output in_valid, in_key, out_ready,
        output cfg_we, cfg_rule, cfg_field, cfg_op, cfg_value, cfg_en,
        input  in_ready, out_valid, out_hit, out_idx, cfg_ready,
        input  lookup_cnt, hit_cnt
    );

    modport slave (
        input  in_valid, in_key, out_ready,
        input  cfg_we, cfg_rule, cfg_field, cfg_op, cfg_value, cfg_en,
        output in_ready, out_valid, out_hit, out_idx, cfg_ready,
        output lookup_cnt, hit_cnt
    );
endinterface

// File: rtl/chained_match_pipe.sv
// rtl/chained_match_pipe.sv - pipelined multi-field rule matcher, one key field per stage
module chained_match_pipe #(
    parameter int FIELD_W    = 2,
    parameter int NUM_FIELDS = 2,
    parameter int NUM_RULES  = 4
) (
    input logic             clk,
    input logic             rst_n,
    chained_match_pipe_if.slave bus
);
    localparam int N     = NUM_FIELDS;
    localparam int R     = NUM_RULES;
    localparam int KEY_W = FIELD_W * NUM_FIELDS;
    localparam int IDX_W = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;
    // Intermediate registers sit between stages; the last stage writes the output register
    localparam int P     = (N > 1) ? N - 1 : 1;

    // Rule table
    logic [R-1:0]                         en_q;
    logic [R-1:0][N-1:0][1:0]             op_q;
    logic [R-1:0][N-1:0][FIELD_W-1:0]     val_q;

    // Inter-stage registers
    logic [P-1:0]       vld_q;
    logic [KEY_W-1:0]   key_q   [P];
    logic [R-1:0]       match_q [P];

    // Output register and counters
    logic               out_valid_q;
    logic               out_hit_q;
    logic [IDX_W-1:0]   out_idx_q;
    logic [15:0]        lookup_cnt_q;
    logic [15:0]        hit_cnt_q;

    // Per-stage combinational view
    logic [N-1:0]       stage_vld;
    logic [KEY_W-1:0]   stage_key [N];
    logic [R-1:0]       stage_in  [N];
    logic [R-1:0]       stage_out [N];

    logic               out_hit_d;
    logic [IDX_W-1:0]   out_idx_d;
    logic               adv;
    logic               pipe_empty;
    logic               cfg_acc;
    logic               key_acc;
    logic               res_hs;

    function automatic logic field_hit(input logic [1:0]         op,
                                       input logic [FIELD_W-1:0] k,
                                       input logic [FIELD_W-1:0] v);
        case (op)
            2'b00:   field_hit = 1'b1;
            2'b01:   field_hit = (k == v);
            2'b10:   field_hit = (k < v);
            default: field_hit = (k > v);
        endcase
    endfunction

    assign adv        = ~out_valid_q | bus.out_ready;
    assign pipe_empty = ~(|vld_q) & ~out_valid_q;
    assign cfg_acc    = bus.cfg_we & pipe_empty;
    assign key_acc    = bus.in_valid & bus.in_ready;
    assign res_hs     = out_valid_q & bus.out_ready;

    assign bus.in_ready   = adv & ~cfg_acc;
    assign bus.cfg_ready  = pipe_empty;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_hit    = out_hit_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.lookup_cnt = lookup_cnt_q;
    assign bus.hit_cnt    = hit_cnt_q;

    // Stage s compares field s of its key against every rule and ANDs into the incoming vector
    always_comb begin
        stage_vld[0] = key_acc;
        stage_key[0] = bus.in_key;
        stage_in[0]  = en_q;
        for (int s = 1; s < N; s++) begin
            stage_vld[s] = vld_q[s-1];
            stage_key[s] = key_q[s-1];
            stage_in[s]  = match_q[s-1];
        end
        for (int s = 0; s < N; s++) begin
            for (int r = 0; r < R; r++) begin
                stage_out[s][r] = stage_in[s][r] &
                    field_hit(op_q[r][s], stage_key[s][s*FIELD_W +: FIELD_W], val_q[r][s]);
            end
        end
    end

    // Lowest-index matching rule of the final stage wins
    always_comb begin
        out_hit_d = |stage_out[N-1];
        out_idx_d = '0;
        for (int r = R - 1; r >= 0; r--) begin
            if (stage_out[N-1][r]) begin
                out_idx_d = IDX_W'(r);
            end
        end
    end

    // Rule table: a write lands only when the pipe is empty, so no in-flight key sees a partial rule
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q  <= '0;
            op_q  <= '0;
            val_q <= '0;
        end else if (cfg_acc) begin
            en_q[bus.cfg_rule]                 <= bus.cfg_en;
            op_q[bus.cfg_rule][bus.cfg_field]  <= bus.cfg_op;
            val_q[bus.cfg_rule][bus.cfg_field] <= bus.cfg_value;
        end
    end

    // Pipeline advances as a whole; a stalled output freezes every stage, bubbles included
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            for (int s = 0; s < P; s++) begin
                key_q[s]   <= '0;
                match_q[s] <= '0;
            end
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_idx_q   <= '0;
        end else if (adv) begin
            for (int s = 0; s < N - 1; s++) begin
                vld_q[s]   <= stage_vld[s];
                key_q[s]   <= stage_key[s];
                match_q[s] <= stage_out[s];
            end
            out_valid_q <= stage_vld[N-1];
            out_hit_q   <= stage_vld[N-1] & out_hit_d;
            out_idx_q   <= stage_vld[N-1] ? out_idx_d : '0;
        end
    end

    // Saturating lookup and hit counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_cnt_q <= '0;
            hit_cnt_q    <= '0;
        end else begin
            if (key_acc && lookup_cnt_q != 16'hFFFF) begin
                lookup_cnt_q <= lookup_cnt_q + 16'd1;
            end
            if (res_hs && out_hit_q && hit_cnt_q != 16'hFFFF) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
        end
    end
endmodule
